// File: rtl/sym_fir_pipelined_if.sv
// Sample-stream handshake bundle for sym_fir_pipelined: input side (data/valid/ready)
// and output side (data/valid/ready). The filter takes the slave view.
interface sym_fir_pipelined_if #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 16
);
  logic signed [IN_W-1:0]  data_in;
  logic                    valid_in;
  logic                    ready_in;
  logic signed [OUT_W-1:0] data_out;
  logic                    valid_out;
  logic                    ready_out;

  modport slave (
    input  data_in, valid_in, ready_out,
    output ready_in, data_out, valid_out
  );

  modport master (
    output data_in, valid_in, ready_out,
    input  ready_in, data_out, valid_out
  );
endinterface

// File: rtl/sym_fir_pipelined.sv
// Fully pipelined symmetric FIR: pre-add, one multiplier per unique coefficient, registered
// adder tree, round/saturate. Define SYM_FIR_SAT_FLAG_EN to add sticky sat_flag/sat_clr.
module sym_fir_pipelined #(
  parameter int unsigned INPUT_WORD_SIZE  = 16,
  parameter int unsigned COEFF_WORD_SIZE  = 16,
  parameter int unsigned N_TAPS           = 11,
  parameter logic [((N_TAPS+1)/2)-1:0][COEFF_WORD_SIZE-1:0] COEFFS =
      {16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1},
  parameter int unsigned OUTPUT_WORD_SIZE = 16,
  parameter int unsigned FRAC_SHIFT       = 0
) (
  input  logic clk,
  input  logic arst_n,
  input  logic flush,
`ifdef SYM_FIR_SAT_FLAG_EN
  input  logic sat_clr,
  output logic sat_flag,
`endif
  sym_fir_pipelined_if.slave bus
);

  localparam int unsigned M     = (N_TAPS + 1) / 2;
  localparam int unsigned NPAIR = N_TAPS / 2;
  localparam int unsigned L     = $clog2(M);
  localparam int unsigned PRE_W = INPUT_WORD_SIZE + 1;
  localparam int unsigned ACC_W = INPUT_WORD_SIZE + 1 + COEFF_WORD_SIZE + L + 1;
  localparam int unsigned DLY_N = (N_TAPS > 1) ? N_TAPS - 1 : 1;
  // pre, products, L tree levels, output register
  localparam int unsigned NSTG  = L + 3;

  localparam logic signed [ACC_W-1:0] OUT_MAX =
      {{(ACC_W-OUTPUT_WORD_SIZE+1){1'b0}}, {(OUTPUT_WORD_SIZE-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN =
      {{(ACC_W-OUTPUT_WORD_SIZE+1){1'b1}}, {(OUTPUT_WORD_SIZE-1){1'b0}}};
  localparam logic signed [OUTPUT_WORD_SIZE-1:0] OUT_MAX_O =
      {1'b0, {(OUTPUT_WORD_SIZE-1){1'b1}}};
  localparam logic signed [OUTPUT_WORD_SIZE-1:0] OUT_MIN_O =
      {1'b1, {(OUTPUT_WORD_SIZE-1){1'b0}}};

  // Number of live partial sums at a given tree level.
  function automatic int unsigned lvl_cnt(input int unsigned lvl);
    return (M + (1 << lvl) - 1) >> lvl;
  endfunction

  logic                               en;
  logic                               ready_in;
  logic                               accept;
  logic signed [INPUT_WORD_SIZE-1:0]  win   [N_TAPS];
  logic signed [INPUT_WORD_SIZE-1:0]  dly_q [DLY_N];
  logic signed [INPUT_WORD_SIZE-1:0]  dly_d [DLY_N];
  logic signed [PRE_W-1:0]            pre_q [M];
  logic signed [PRE_W-1:0]            pre_d [M];
  logic signed [ACC_W-1:0]            lvl_q [L+1][M];
  logic signed [ACC_W-1:0]            lvl_d [L+1][M];
  logic [NSTG-1:0]                    vld_q, vld_d;
  logic signed [OUTPUT_WORD_SIZE-1:0] dout_q, dout_d;
  logic signed [ACC_W-1:0]            shifted;
  logic                               clamp_hi, clamp_lo;
  logic signed [OUTPUT_WORD_SIZE-1:0] sat_val;

  assign en       = !vld_q[NSTG-1] || bus.ready_out;
  assign ready_in = en && !flush;
  assign accept   = bus.valid_in && ready_in;

  assign bus.ready_in  = ready_in;
  assign bus.valid_out = vld_q[NSTG-1];
  assign bus.data_out  = dout_q;

  always_comb begin
    win[0] = bus.data_in;
    for (int k = 1; k < int'(N_TAPS); k++) begin
      win[k] = dly_q[k-1];
    end
  end

  if (FRAC_SHIFT > 0) begin : g_round
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC_SHIFT - 1);
    assign shifted = (lvl_q[L][0] + HALF) >>> FRAC_SHIFT;
  end else begin : g_noround
    assign shifted = lvl_q[L][0];
  end

  always_comb begin
    clamp_hi = shifted > OUT_MAX;
    clamp_lo = shifted < OUT_MIN;
    if (clamp_hi) begin
      sat_val = OUT_MAX_O;
    end else if (clamp_lo) begin
      sat_val = OUT_MIN_O;
    end else begin
      sat_val = shifted[OUTPUT_WORD_SIZE-1:0];
    end
  end

  always_comb begin
    dly_d  = dly_q;
    pre_d  = pre_q;
    lvl_d  = lvl_q;
    vld_d  = vld_q;
    dout_d = dout_q;
    if (flush) begin
      for (int k = 0; k < int'(DLY_N); k++) begin
        dly_d[k] = '0;
      end
      vld_d  = '0;
      dout_d = '0;
    end else if (en) begin
      if (accept) begin
        dly_d[0] = bus.data_in;
        for (int k = 1; k < int'(DLY_N); k++) begin
          dly_d[k] = dly_q[k-1];
        end
      end
      for (int i = 0; i < int'(NPAIR); i++) begin
        pre_d[i] = PRE_W'(win[i]) + PRE_W'(win[N_TAPS-1-i]);
      end
      if (N_TAPS % 2 == 1) begin
        pre_d[M-1] = PRE_W'(win[M-1]);
      end
      for (int i = 0; i < int'(M); i++) begin
        lvl_d[0][i] = ACC_W'(pre_q[i]) * ACC_W'($signed(COEFFS[i]));
      end
      // Pair neighbours; an unpaired tail element is carried through a register.
      for (int l = 1; l <= int'(L); l++) begin
        for (int j = 0; j < int'(M); j++) begin
          if (2 * j + 1 < int'(lvl_cnt(l - 1))) begin
            lvl_d[l][j] = lvl_q[l-1][2*j] + lvl_q[l-1][2*j+1];
          end else if (2 * j < int'(lvl_cnt(l - 1))) begin
            lvl_d[l][j] = lvl_q[l-1][2*j];
          end else begin
            lvl_d[l][j] = '0;
          end
        end
      end
      vld_d = {vld_q[NSTG-2:0], accept};
      if (vld_q[NSTG-2]) begin
        dout_d = sat_val;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int k = 0; k < int'(DLY_N); k++) begin
        dly_q[k] <= '0;
      end
      for (int i = 0; i < int'(M); i++) begin
        pre_q[i] <= '0;
        for (int l = 0; l <= int'(L); l++) begin
          lvl_q[l][i] <= '0;
        end
      end
      vld_q  <= '0;
      dout_q <= '0;
    end else begin
      dly_q  <= dly_d;
      pre_q  <= pre_d;
      lvl_q  <= lvl_d;
      vld_q  <= vld_d;
      dout_q <= dout_d;
    end
  end

`ifdef SYM_FIR_SAT_FLAG_EN
  logic sat_flag_q, sat_flag_d;

  always_comb begin
    sat_flag_d = sat_flag_q;
    if (flush) begin
      sat_flag_d = 1'b0;
    end else begin
      if (sat_clr) begin
        sat_flag_d = 1'b0;
      end
      if (en && vld_q[NSTG-2] && (clamp_hi || clamp_lo)) begin
        sat_flag_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sat_flag_q <= 1'b0;
    end else begin
      sat_flag_q <= sat_flag_d;
    end
  end

  assign sat_flag = sat_flag_q;
`endif

endmodule

// File: tb/tb_sym_fir_pipelined.sv
// Directed bench for sym_fir_pipelined: default, even-tap and rounding/saturating instances.
module tb_sym_fir_pipelined;

  logic clk = 1'b0;
  logic arst_n;
  logic flush;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  sym_fir_pipelined_if #(.IN_W(16), .OUT_W(16)) bus_def ();
  sym_fir_pipelined_if #(.IN_W(16), .OUT_W(16)) bus_even ();
  sym_fir_pipelined_if #(.IN_W(16), .OUT_W(16)) bus_rnd ();

`ifdef SYM_FIR_SAT_FLAG_EN
  logic sat_clr;
  logic sat_flag, sat_flag_even, sat_flag_rnd;
`endif

  sym_fir_pipelined u_def (
    .clk     (clk),
    .arst_n  (arst_n),
    .flush   (flush),
`ifdef SYM_FIR_SAT_FLAG_EN
    .sat_clr (sat_clr),
    .sat_flag(sat_flag),
`endif
    .bus     (bus_def)
  );

  sym_fir_pipelined #(
    .N_TAPS(4),
    .COEFFS({16'd3, 16'd2})
  ) u_even (
    .clk     (clk),
    .arst_n  (arst_n),
    .flush   (1'b0),
`ifdef SYM_FIR_SAT_FLAG_EN
    .sat_clr (1'b0),
    .sat_flag(sat_flag_even),
`endif
    .bus     (bus_even)
  );

  sym_fir_pipelined #(
    .N_TAPS    (1),
    .COEFFS    (16'd3),
    .FRAC_SHIFT(1)
  ) u_rnd (
    .clk     (clk),
    .arst_n  (arst_n),
    .flush   (1'b0),
`ifdef SYM_FIR_SAT_FLAG_EN
    .sat_clr (1'b0),
    .sat_flag(sat_flag_rnd),
`endif
    .bus     (bus_rnd)
  );

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    bus_def.valid_in = 1'b0;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    #1;
    n_cmp += 6;
    if (bus_def.valid_out !== 1'b0 || bus_def.data_out !== 16'sd0) begin
      n_err++;
      $display("FAIL reset_def_out: got v=%b d=%0d want v=0 d=0", bus_def.valid_out,
               bus_def.data_out);
    end
    if (bus_def.ready_in !== 1'b1) begin
      n_err++;
      $display("FAIL reset_def_ready: got %b want 1", bus_def.ready_in);
    end
    if (bus_even.valid_out !== 1'b0 || bus_even.data_out !== 16'sd0) begin
      n_err++;
      $display("FAIL reset_even_out: got v=%b d=%0d want v=0 d=0", bus_even.valid_out,
               bus_even.data_out);
    end
    if (bus_even.ready_in !== 1'b1) begin
      n_err++;
      $display("FAIL reset_even_ready: got %b want 1", bus_even.ready_in);
    end
    if (bus_rnd.valid_out !== 1'b0 || bus_rnd.data_out !== 16'sd0) begin
      n_err++;
      $display("FAIL reset_rnd_out: got v=%b d=%0d want v=0 d=0", bus_rnd.valid_out,
               bus_rnd.data_out);
    end
    if (bus_rnd.ready_in !== 1'b1) begin
      n_err++;
      $display("FAIL reset_rnd_ready: got %b want 1", bus_rnd.ready_in);
    end
`ifdef SYM_FIR_SAT_FLAG_EN
    n_cmp++;
    if (sat_flag !== 1'b0) begin
      n_err++;
      $display("FAIL reset_sat_flag: got %b want 0", sat_flag);
    end
`endif
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  // Impulse on the default 11-tap instance; output appears 6 enabled cycles after accept.
  task automatic test_impulse(input string tag);
    int h[11] = '{1, 2, 3, 4, 5, 6, 5, 4, 3, 2, 1};
    logic exp_v;
    logic signed [15:0] exp_d;
    for (int it = 0; it < 24; it++) begin
      @(negedge clk);
      bus_def.ready_out = 1'b1;
      bus_def.valid_in  = (it < 16);
      bus_def.data_in   = (it == 0) ? 16'sd1 : 16'sd0;
      #1;
      exp_v = (it >= 6) && (it < 22);
      exp_d = (it >= 6 && it - 6 < 11) ? 16'(h[it-6]) : 16'sd0;
      n_cmp++;
      if (bus_def.valid_out !== exp_v) begin
        n_err++;
        $display("FAIL %s_valid[%0d]: got %b want %b", tag, it, bus_def.valid_out, exp_v);
      end
      if (exp_v) begin
        n_cmp++;
        if (bus_def.data_out !== exp_d) begin
          n_err++;
          $display("FAIL %s_data[%0d]: got %0d want %0d", tag, it, bus_def.data_out, exp_d);
        end
      end
    end
    @(negedge clk);
    bus_def.valid_in = 1'b0;
  endtask

  task automatic test_even_taps();
    int h[4] = '{2, 3, 3, 2};
    logic exp_v;
    logic signed [15:0] exp_d;
    for (int it = 0; it < 14; it++) begin
      @(negedge clk);
      bus_even.ready_out = 1'b1;
      bus_even.valid_in  = (it < 8);
      bus_even.data_in   = (it == 0) ? 16'sd1 : 16'sd0;
      #1;
      exp_v = (it >= 4) && (it < 12);
      exp_d = (it >= 4 && it - 4 < 4) ? 16'(h[it-4]) : 16'sd0;
      n_cmp++;
      if (bus_even.valid_out !== exp_v) begin
        n_err++;
        $display("FAIL even_valid[%0d]: got %b want %b", it, bus_even.valid_out, exp_v);
      end
      if (exp_v) begin
        n_cmp++;
        if (bus_even.data_out !== exp_d) begin
          n_err++;
          $display("FAIL even_data[%0d]: got %0d want %0d", it, bus_even.data_out, exp_d);
        end
      end
    end
    bus_even.valid_in = 1'b0;
  endtask

  task automatic test_backpressure();
    int h[11] = '{1, 2, 3, 4, 5, 6, 5, 4, 3, 2, 1};
    int exp_y[20];
    int in_idx = 0;
    int out_idx = 0;
    for (int n = 0; n < 20; n++) begin
      exp_y[n] = 0;
      for (int k = 0; k < 11; k++) begin
        if (n - k >= 0) exp_y[n] += h[k] * (n - k + 1);
      end
    end
    do_flush();
    for (int it = 0; it < 60; it++) begin
      @(negedge clk);
      bus_def.valid_in  = (in_idx < 20);
      bus_def.data_in   = 16'(in_idx + 1);
      bus_def.ready_out = !(it >= 10 && it < 15);
      #1;
      if (!bus_def.ready_out) begin
        n_cmp += 3;
        if (bus_def.ready_in !== 1'b0) begin
          n_err++;
          $display("FAIL bp_stall_ready[%0d]: got %b want 0", it, bus_def.ready_in);
        end
        if (bus_def.valid_out !== 1'b1) begin
          n_err++;
          $display("FAIL bp_stall_valid[%0d]: got %b want 1", it, bus_def.valid_out);
        end
        if (out_idx >= 20 || bus_def.data_out !== 16'(exp_y[out_idx])) begin
          n_err++;
          $display("FAIL bp_stall_hold[%0d]: got %0d want %0d", it, bus_def.data_out,
                   (out_idx < 20) ? exp_y[out_idx] : 0);
        end
      end
      if (bus_def.valid_in && bus_def.ready_in) in_idx++;
      if (bus_def.valid_out && bus_def.ready_out) begin
        n_cmp++;
        if (out_idx >= 20) begin
          n_err++;
          $display("FAIL bp_extra[%0d]: got %0d want no output", it, bus_def.data_out);
        end else if (bus_def.data_out !== 16'(exp_y[out_idx])) begin
          n_err++;
          $display("FAIL bp_data[%0d]: got %0d want %0d", out_idx, bus_def.data_out,
                   exp_y[out_idx]);
        end
        out_idx++;
      end
    end
    n_cmp += 2;
    if (in_idx != 20) begin
      n_err++;
      $display("FAIL bp_in_count: got %0d want 20", in_idx);
    end
    if (out_idx != 20) begin
      n_err++;
      $display("FAIL bp_out_count: got %0d want 20", out_idx);
    end
    bus_def.valid_in  = 1'b0;
    bus_def.ready_out = 1'b1;
  endtask

  task automatic test_saturation();
    logic signed [15:0] rin[6]  = '{16'sd1, -16'sd1, 16'sd32767, -16'sd32768, 16'sd0, 16'sd3};
    logic signed [15:0] rexp[6] = '{16'sd2, -16'sd1, 16'sd32767, -16'sd32768, 16'sd0, 16'sd5};
    logic exp_v;
    do_flush();
`ifdef SYM_FIR_SAT_FLAG_EN
    n_cmp++;
    if (sat_flag !== 1'b0) begin
      n_err++;
      $display("FAIL sat_flag_pre: got %b want 0", sat_flag);
    end
`endif
    for (int it = 0; it < 24; it++) begin
      @(negedge clk);
      bus_def.ready_out = 1'b1;
      bus_def.valid_in  = (it < 16);
      bus_def.data_in   = 16'sd32767;
      #1;
      exp_v = (it >= 6) && (it < 22);
      n_cmp++;
      if (bus_def.valid_out !== exp_v) begin
        n_err++;
        $display("FAIL sat_valid[%0d]: got %b want %b", it, bus_def.valid_out, exp_v);
      end
      if (exp_v) begin
        n_cmp++;
        if (bus_def.data_out !== 16'sd32767) begin
          n_err++;
          $display("FAIL sat_data[%0d]: got %0d want 32767", it, bus_def.data_out);
        end
      end
    end
    bus_def.valid_in = 1'b0;
`ifdef SYM_FIR_SAT_FLAG_EN
    n_cmp++;
    if (sat_flag !== 1'b1) begin
      n_err++;
      $display("FAIL sat_flag_set: got %b want 1", sat_flag);
    end
    @(negedge clk);
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    n_cmp++;
    if (sat_flag !== 1'b0) begin
      n_err++;
      $display("FAIL sat_flag_clr: got %b want 0", sat_flag);
    end
`endif
    // Single-tap x3 with one fractional bit: round half up, then clamp.
    for (int it = 0; it < 11; it++) begin
      @(negedge clk);
      bus_rnd.ready_out = 1'b1;
      bus_rnd.valid_in  = (it < 6);
      bus_rnd.data_in   = (it < 6) ? rin[it] : 16'sd0;
      #1;
      exp_v = (it >= 3) && (it < 9);
      n_cmp++;
      if (bus_rnd.valid_out !== exp_v) begin
        n_err++;
        $display("FAIL rnd_valid[%0d]: got %b want %b", it, bus_rnd.valid_out, exp_v);
      end
      if (exp_v) begin
        n_cmp++;
        if (bus_rnd.data_out !== rexp[it-3]) begin
          n_err++;
          $display("FAIL rnd_data[%0d]: got %0d want %0d", it - 3, bus_rnd.data_out,
                   rexp[it-3]);
        end
      end
    end
    bus_rnd.valid_in = 1'b0;
  endtask

  task automatic test_flush();
    do_flush();
    for (int it = 0; it < 14; it++) begin
      @(negedge clk);
      bus_def.ready_out = 1'b1;
      flush             = (it == 3);
      bus_def.valid_in  = (it <= 3);
      bus_def.data_in   = (it == 3) ? 16'sd100 : 16'sd7;
      #1;
      if (it == 3) begin
        n_cmp++;
        if (bus_def.ready_in !== 1'b0) begin
          n_err++;
          $display("FAIL flush_ready: got %b want 0", bus_def.ready_in);
        end
      end
      if (it >= 4) begin
        n_cmp++;
        if (bus_def.valid_out !== 1'b0) begin
          n_err++;
          $display("FAIL flush_valid[%0d]: got %b want 0", it, bus_def.valid_out);
        end
      end
      if (it == 4) begin
        n_cmp++;
        if (bus_def.data_out !== 16'sd0) begin
          n_err++;
          $display("FAIL flush_data: got %0d want 0", bus_def.data_out);
        end
      end
    end
    flush            = 1'b0;
    bus_def.valid_in = 1'b0;
    test_impulse("post_flush");
  endtask

  task automatic test_reset_midstream();
    for (int it = 0; it < 12; it++) begin
      @(negedge clk);
      bus_def.valid_in  = 1'b1;
      bus_def.data_in   = 16'(it + 1);
      bus_def.ready_out = (it < 8);
    end
    #1;
    n_cmp++;
    if (bus_def.valid_out !== 1'b1 || bus_def.ready_in !== 1'b0) begin
      n_err++;
      $display("FAIL rst_pre_stall: got v=%b r=%b want v=1 r=0", bus_def.valid_out,
               bus_def.ready_in);
    end
    @(posedge clk);
    #2;
    arst_n = 1'b0;
    #1;
    n_cmp += 2;
    if (bus_def.valid_out !== 1'b0 || bus_def.data_out !== 16'sd0) begin
      n_err++;
      $display("FAIL rst_mid_out: got v=%b d=%0d want v=0 d=0", bus_def.valid_out,
               bus_def.data_out);
    end
    if (bus_def.ready_in !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_ready: got %b want 1", bus_def.ready_in);
    end
    @(negedge clk);
    bus_def.valid_in  = 1'b0;
    bus_def.ready_out = 1'b1;
    arst_n = 1'b1;
    test_impulse("post_reset");
  endtask

  initial begin
    flush = 1'b0;
`ifdef SYM_FIR_SAT_FLAG_EN
    sat_clr = 1'b0;
`endif
    bus_def.data_in  = '0; bus_def.valid_in  = 1'b0; bus_def.ready_out  = 1'b1;
    bus_even.data_in = '0; bus_even.valid_in = 1'b0; bus_even.ready_out = 1'b1;
    bus_rnd.data_in  = '0; bus_rnd.valid_in  = 1'b0; bus_rnd.ready_out  = 1'b1;
    test_reset();
    test_impulse("impulse");
    test_even_taps();
    test_backpressure();
    test_saturation();
    test_flush();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
